// File: rtl/prog_pulse_sequencer.sv
// Timed VPP/PGM programming-pulse sequencer: setup, N x (pulse, recover), done.
// Define SEQ_VERIFY_EN to add a one-cycle VERIFY phase after each recover.
module prog_pulse_sequencer #(
  parameter int CLK_PER_US = 24,
  parameter int TIME_BITS  = 12,
  parameter int COUNT_BITS = 8
) (
  input  logic                  osc,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TIME_BITS-1:0]  setup_us,
  input  logic [TIME_BITS-1:0]  pulse_us,
  input  logic [TIME_BITS-1:0]  recover_us,
  input  logic [COUNT_BITS-1:0] pulse_count,
  input  logic                  verify_ok,
  output logic                  vpp_en,
  output logic                  pgm_n,
  output logic                  busy,
  output logic                  done,
  output logic                  verify_fail,
  output logic [COUNT_BITS-1:0] pulses_done
);

  localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(CLK_PER_US - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_RECOVER,
`ifdef SEQ_VERIFY_EN
    ST_VERIFY,
`endif
    ST_DONE
  } state_t;

  state_t                state_q, state_next;
  logic [TIME_BITS-1:0]  us_cnt;
  logic [PRE_W-1:0]      pre_cnt;
  logic [TIME_BITS-1:0]  cap_pulse, cap_recover;
  logic [COUNT_BITS-1:0] cap_count;
  logic [TIME_BITS-1:0]  load_val;
  logic                  load_timer, inc_pulse, capture;
  logic                  tmr_exp, pulses_left, active_next;
`ifdef SEQ_VERIFY_EN
  logic                  set_vfail;
`endif

  // A phase of N us expires on its last cycle; N=0 expires on its entry cycle.
  assign tmr_exp     = (us_cnt == '0) || ((us_cnt == TIME_BITS'(1)) && (pre_cnt == '0));
  assign pulses_left = (pulses_done < cap_count);
  assign active_next = (state_next != ST_IDLE) && (state_next != ST_DONE);

  always_ff @(posedge osc or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    load_timer = 1'b0;
    load_val   = cap_pulse;
    inc_pulse  = 1'b0;
    capture    = 1'b0;
`ifdef SEQ_VERIFY_EN
    set_vfail  = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_SETUP;
          capture    = 1'b1;
          load_timer = 1'b1;
          load_val   = setup_us;
        end
      end
      ST_SETUP: begin
        if (tmr_exp) begin
          if (cap_count == '0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_PULSE;
            load_timer = 1'b1;
          end
        end
      end
      ST_PULSE: begin
        if (tmr_exp) begin
          state_next = ST_RECOVER;
          load_timer = 1'b1;
          load_val   = cap_recover;
          inc_pulse  = 1'b1;
        end
      end
      ST_RECOVER: begin
        if (tmr_exp) begin
`ifdef SEQ_VERIFY_EN
          state_next = ST_VERIFY;
`else
          if (pulses_left) begin
            state_next = ST_PULSE;
            load_timer = 1'b1;
          end else begin
            state_next = ST_DONE;
          end
`endif
        end
      end
`ifdef SEQ_VERIFY_EN
      ST_VERIFY: begin
        if (verify_ok) begin
          state_next = ST_DONE;
        end else if (pulses_left) begin
          state_next = ST_PULSE;
          load_timer = 1'b1;
        end else begin
          state_next = ST_DONE;
          set_vfail  = 1'b1;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
    // Abort overrides everything, including a start in the same cycle.
    if (abort) begin
      state_next = ST_IDLE;
      load_timer = 1'b0;
      inc_pulse  = 1'b0;
      capture    = 1'b0;
`ifdef SEQ_VERIFY_EN
      set_vfail  = 1'b0;
`endif
    end
  end

  always_ff @(posedge osc or negedge nreset) begin
    if (!nreset) begin
      us_cnt  <= '0;
      pre_cnt <= '0;
    end else if (abort) begin
      us_cnt  <= '0;
      pre_cnt <= '0;
    end else if (load_timer) begin
      us_cnt  <= load_val;
      pre_cnt <= PRE_TOP;
    end else if (us_cnt != '0) begin
      if (pre_cnt == '0) begin
        us_cnt  <= us_cnt - 1'b1;
        pre_cnt <= PRE_TOP;
      end else begin
        pre_cnt <= pre_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge osc or negedge nreset) begin
    if (!nreset) begin
      cap_pulse   <= '0;
      cap_recover <= '0;
      cap_count   <= '0;
    end else if (capture) begin
      cap_pulse   <= pulse_us;
      cap_recover <= recover_us;
      cap_count   <= pulse_count;
    end
  end

  // Outputs are registered copies of the next-state decode.
  always_ff @(posedge osc or negedge nreset) begin
    if (!nreset) begin
      vpp_en      <= 1'b0;
      pgm_n       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_done <= '0;
    end else begin
      vpp_en <= active_next;
      busy   <= active_next;
      pgm_n  <= (state_next != ST_PULSE);
      done   <= (state_next == ST_DONE);
      if (capture) begin
        pulses_done <= '0;
      end else if (inc_pulse) begin
        pulses_done <= pulses_done + 1'b1;
      end
    end
  end

`ifdef SEQ_VERIFY_EN
  always_ff @(posedge osc or negedge nreset) begin
    if (!nreset) begin
      verify_fail <= 1'b0;
    end else if (capture) begin
      verify_fail <= 1'b0;
    end else if (set_vfail) begin
      verify_fail <= 1'b1;
    end
  end
`else
  logic unused_verify_ok;
  assign unused_verify_ok = verify_ok;
  assign verify_fail      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_pulse_sequencer.sv
// Directed self-checking bench for prog_pulse_sequencer (default 24 cycles/us).
// Expected cycle counts account for the extra VERIFY cycle when SEQ_VERIFY_EN is defined.
module tb_prog_pulse_sequencer;

`ifdef SEQ_VERIFY_EN
  localparam int VCYC = 1;
`else
  localparam int VCYC = 0;
`endif

  logic        osc = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] setup_us = '0;
  logic [11:0] pulse_us = '0;
  logic [11:0] recover_us = '0;
  logic [7:0]  pulse_count = '0;
  logic        verify_ok = 1'b0;
  logic        vpp_en, pgm_n, busy, done, verify_fail;
  logic [7:0]  pulses_done;

  int checks = 0;
  int errors = 0;

  int nf, nr, vpp_rise, vpp_fall, unsafe;
  int fall_at[32];
  int rise_at[32];
  int pd_at_rise[32];
  bit timed_out;

  prog_pulse_sequencer #(.CLK_PER_US(24), .TIME_BITS(12), .COUNT_BITS(8)) dut (
    .osc(osc), .nreset(nreset), .start(start), .abort(abort),
    .setup_us(setup_us), .pulse_us(pulse_us), .recover_us(recover_us),
    .pulse_count(pulse_count), .verify_ok(verify_ok),
    .vpp_en(vpp_en), .pgm_n(pgm_n), .busy(busy), .done(done),
    .verify_fail(verify_fail), .pulses_done(pulses_done)
  );

  always #5 osc = ~osc;

  // Loads the times and pulses start for one cycle; returns at the first negedge in SETUP.
  task automatic applyStimulus(input int s, input int p, input int r, input int c);
    @(negedge osc);
    setup_us    = 12'(s);
    pulse_us    = 12'(p);
    recover_us  = 12'(r);
    pulse_count = 8'(c);
    start       = 1'b1;
    @(negedge osc);
    start = 1'b0;
  endtask

  // Records edge times (in cycles from the call) until done rises or the budget runs out.
  task automatic measure(input int max_cycles, input bit scramble);
    logic prev_pgm, prev_vpp;
    prev_pgm = 1'b1; prev_vpp = 1'b0;
    nf = 0; nr = 0; vpp_rise = -1; vpp_fall = -1; unsafe = 0; timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      if (vpp_en === 1'b1 && prev_vpp === 1'b0 && vpp_rise < 0) vpp_rise = c;
      if (vpp_en === 1'b0 && prev_vpp === 1'b1 && vpp_fall < 0) vpp_fall = c;
      if (pgm_n === 1'b0 && prev_pgm === 1'b1 && nf < 32) begin
        fall_at[nf] = c; nf++;
      end
      if (pgm_n === 1'b1 && prev_pgm === 1'b0 && nr < 32) begin
        rise_at[nr] = c; pd_at_rise[nr] = int'(pulses_done); nr++;
      end
      if (pgm_n === 1'b0 && vpp_en !== 1'b1) unsafe++;
      prev_pgm = pgm_n;
      prev_vpp = vpp_en;
      if (scramble && c == 3) begin
        setup_us = 12'd0; pulse_us = 12'd1; recover_us = 12'd0; pulse_count = 8'd1;
      end
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge osc);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (2) @(negedge osc);
    checks++; if (vpp_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_vpp_en: got %b expected 0", vpp_en); end
    checks++; if (pgm_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_pgm_n: got %b expected 1", pgm_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (verify_fail !== 1'b0) begin errors++; $display("[TB] FAIL reset_verify_fail: got %b expected 0", verify_fail); end
    checks++; if (pulses_done !== 8'd0) begin errors++; $display("[TB] FAIL reset_pulses_done: got %0d expected 0", pulses_done); end
    nreset = 1'b1;
    repeat (3) @(negedge osc);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_pulse_train();
    applyStimulus(2, 100, 5, 3);
    measure(20000, 1'b1);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL train_timeout: got timeout expected done"); end
    checks++; if (nf !== 3) begin errors++; $display("[TB] FAIL train_pulses: got %0d expected 3", nf); end
    checks++; if (fall_at[0] - vpp_rise !== 48) begin errors++; $display("[TB] FAIL train_setup: got %0d expected 48", fall_at[0] - vpp_rise); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rise_at[i] - fall_at[i] !== 2400) begin errors++; $display("[TB] FAIL train_width%0d: got %0d expected 2400", i, rise_at[i] - fall_at[i]); end
      checks++; if (pd_at_rise[i] !== i + 1) begin errors++; $display("[TB] FAIL train_count_at_rise%0d: got %0d expected %0d", i, pd_at_rise[i], i + 1); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (fall_at[i+1] - rise_at[i] !== 120 + VCYC) begin errors++; $display("[TB] FAIL train_gap%0d: got %0d expected %0d", i, fall_at[i+1] - rise_at[i], 120 + VCYC); end
    end
    checks++; if (vpp_fall - rise_at[2] !== 120 + VCYC) begin errors++; $display("[TB] FAIL train_vpp_off: got %0d expected %0d", vpp_fall - rise_at[2], 120 + VCYC); end
    checks++; if (pulses_done !== 8'd3) begin errors++; $display("[TB] FAIL train_pulses_done: got %0d expected 3", pulses_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL train_busy: got %b expected 0", busy); end
    checks++; if (unsafe !== 0) begin errors++; $display("[TB] FAIL train_pgm_without_vpp: got %0d expected 0", unsafe); end
    checks++; if (verify_fail !== 1'(VCYC)) begin errors++; $display("[TB] FAIL train_verify_fail: got %b expected %0d", verify_fail, VCYC); end
    repeat (20) @(negedge osc);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL done_sticky: got %b expected 1", done); end
  endtask

  task automatic test_zero_count();
    applyStimulus(1, 5, 5, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_busy: got %b expected 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_clear: got %b expected 0", done); end
    measure(1000, 1'b0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL zero_timeout: got timeout expected done"); end
    checks++; if (nf !== 0) begin errors++; $display("[TB] FAIL zero_pulses: got %0d expected 0", nf); end
    checks++; if (vpp_fall !== 24) begin errors++; $display("[TB] FAIL zero_setup_len: got %0d expected 24", vpp_fall); end
    checks++; if (pulses_done !== 8'd0) begin errors++; $display("[TB] FAIL zero_pulses_done: got %0d expected 0", pulses_done); end
  endtask

  task automatic test_min_times();
    applyStimulus(0, 0, 0, 2);
    measure(200, 1'b0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL min_timeout: got timeout expected done"); end
    checks++; if (nf !== 2) begin errors++; $display("[TB] FAIL min_pulses: got %0d expected 2", nf); end
    checks++; if (fall_at[0] !== 1) begin errors++; $display("[TB] FAIL min_setup: got %0d expected 1", fall_at[0]); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (rise_at[i] - fall_at[i] !== 1) begin errors++; $display("[TB] FAIL min_width%0d: got %0d expected 1", i, rise_at[i] - fall_at[i]); end
    end
    checks++; if (vpp_fall !== 5 + 2 * VCYC) begin errors++; $display("[TB] FAIL min_total: got %0d expected %0d", vpp_fall, 5 + 2 * VCYC); end
    checks++; if (pulses_done !== 8'd2) begin errors++; $display("[TB] FAIL min_pulses_done: got %0d expected 2", pulses_done); end
    checks++; if (unsafe !== 0) begin errors++; $display("[TB] FAIL min_pgm_without_vpp: got %0d expected 0", unsafe); end
  endtask

  task automatic test_start_while_busy();
    applyStimulus(1, 1, 1, 1);
    repeat (10) @(negedge osc);
    setup_us = 12'd0; pulse_count = 8'd5; start = 1'b1;
    @(negedge osc);
    start = 1'b0;
    measure(2000, 1'b0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL busy_start_timeout: got timeout expected done"); end
    checks++; if (nf !== 1) begin errors++; $display("[TB] FAIL busy_start_pulses: got %0d expected 1", nf); end
    checks++; if (vpp_fall !== 61 + VCYC) begin errors++; $display("[TB] FAIL busy_start_end: got %0d expected %0d", vpp_fall, 61 + VCYC); end
    checks++; if (pulses_done !== 8'd1) begin errors++; $display("[TB] FAIL busy_start_pulses_done: got %0d expected 1", pulses_done); end
  endtask

  task automatic test_abort();
    applyStimulus(1, 2, 1, 3);
    repeat (106) @(negedge osc);
    checks++; if (pgm_n !== 1'b0) begin errors++; $display("[TB] FAIL abort_pre_pgm_n: got %b expected 0", pgm_n); end
    checks++; if (pulses_done !== 8'd1) begin errors++; $display("[TB] FAIL abort_pre_count: got %0d expected 1", pulses_done); end
    abort = 1'b1;
    @(negedge osc);
    abort = 1'b0;
    checks++; if (pgm_n !== 1'b1) begin errors++; $display("[TB] FAIL abort_pgm_n: got %b expected 1", pgm_n); end
    checks++; if (vpp_en !== 1'b0) begin errors++; $display("[TB] FAIL abort_vpp_en: got %b expected 0", vpp_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    checks++; if (pulses_done !== 8'd1) begin errors++; $display("[TB] FAIL abort_count_hold: got %0d expected 1", pulses_done); end
    repeat (30) @(negedge osc);
    checks++; if (busy !== 1'b0 || pgm_n !== 1'b1) begin errors++; $display("[TB] FAIL abort_stays_idle: got busy=%b pgm_n=%b expected busy=0 pgm_n=1", busy, pgm_n); end
    setup_us = 12'd0; pulse_count = 8'd2; abort = 1'b1; start = 1'b1;
    @(negedge osc);
    abort = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0 || vpp_en !== 1'b0) begin errors++; $display("[TB] FAIL abort_start_same: got busy=%b vpp_en=%b expected 0 0", busy, vpp_en); end
    repeat (30) @(negedge osc);
    checks++; if (busy !== 1'b0 || pulses_done !== 8'd1) begin errors++; $display("[TB] FAIL abort_start_dropped: got busy=%b count=%0d expected busy=0 count=1", busy, pulses_done); end
  endtask

  task automatic test_async_reset();
    applyStimulus(0, 10, 0, 1);
    repeat (5) @(negedge osc);
    checks++; if (pgm_n !== 1'b0) begin errors++; $display("[TB] FAIL areset_pre_pgm_n: got %b expected 0", pgm_n); end
    #1 nreset = 1'b0;
    #1;
    checks++; if (pgm_n !== 1'b1) begin errors++; $display("[TB] FAIL areset_pgm_n: got %b expected 1", pgm_n); end
    checks++; if (vpp_en !== 1'b0) begin errors++; $display("[TB] FAIL areset_vpp_en: got %b expected 0", vpp_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL areset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL areset_done: got %b expected 0", done); end
    checks++; if (pulses_done !== 8'd0) begin errors++; $display("[TB] FAIL areset_count: got %0d expected 0", pulses_done); end
    @(negedge osc);
    nreset = 1'b1;
    @(negedge osc);
  endtask

`ifdef SEQ_VERIFY_EN
  task automatic test_verify();
    bit finished;
    applyStimulus(0, 0, 0, 25);
    finished = 1'b0;
    for (int c = 0; c < 500; c++) begin
      verify_ok = (pulses_done >= 8'd4);
      if (done === 1'b1) begin
        finished = 1'b1;
        break;
      end
      @(negedge osc);
    end
    verify_ok = 1'b0;
    checks++; if (!finished) begin errors++; $display("[TB] FAIL verify_early_timeout: got timeout expected done"); end
    checks++; if (pulses_done !== 8'd4) begin errors++; $display("[TB] FAIL verify_early_count: got %0d expected 4", pulses_done); end
    checks++; if (verify_fail !== 1'b0) begin errors++; $display("[TB] FAIL verify_early_fail: got %b expected 0", verify_fail); end
    applyStimulus(0, 0, 0, 25);
    measure(1000, 1'b0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL verify_exhaust_timeout: got timeout expected done"); end
    checks++; if (nf !== 25) begin errors++; $display("[TB] FAIL verify_exhaust_pulses: got %0d expected 25", nf); end
    checks++; if (pulses_done !== 8'd25) begin errors++; $display("[TB] FAIL verify_exhaust_count: got %0d expected 25", pulses_done); end
    checks++; if (verify_fail !== 1'b1) begin errors++; $display("[TB] FAIL verify_exhaust_fail: got %b expected 1", verify_fail); end
  endtask
`else
  task automatic test_verify();
    verify_ok = 1'b1;
    applyStimulus(0, 0, 0, 3);
    measure(200, 1'b0);
    verify_ok = 1'b0;
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL noverify_timeout: got timeout expected done"); end
    checks++; if (nf !== 3) begin errors++; $display("[TB] FAIL noverify_pulses: got %0d expected 3", nf); end
    checks++; if (pulses_done !== 8'd3) begin errors++; $display("[TB] FAIL noverify_count: got %0d expected 3", pulses_done); end
    checks++; if (verify_fail !== 1'b0) begin errors++; $display("[TB] FAIL noverify_fail: got %b expected 0", verify_fail); end
  endtask
`endif

  initial begin
    test_reset();
    test_pulse_train();
    test_zero_count();
    test_min_times();
    test_start_while_busy();
    test_abort();
    test_async_reset();
    test_verify();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
